// File: rtl/md_pad_pkg.sv
// Shared constants for the MD controller-port model: pin layout, button
// indices and the 6-button TH phase encoding.
package md_pad_pkg;

   // Pin layout of one FC1004 port: bit 6 = TH, bits 5..0 = D5..D0
   localparam int PAD_W  = 7;
   localparam int BTN_W  = 12;
   localparam int TH_BIT = 6;

   // Button positions inside one port's 12-bit button vector (active-high)
   localparam int BTN_UP    = 0;
   localparam int BTN_DOWN  = 1;
   localparam int BTN_LEFT  = 2;
   localparam int BTN_RIGHT = 3;
   localparam int BTN_A     = 4;
   localparam int BTN_B     = 5;
   localparam int BTN_C     = 6;
   localparam int BTN_START = 7;
   localparam int BTN_X     = 8;
   localparam int BTN_Y     = 9;
   localparam int BTN_Z     = 10;
   localparam int BTN_MODE  = 11;

   // TH phase counter values. PH_EXT is the phase in which the pad exposes
   // the extra buttons; PH_EXT_LO is the phase after it, whose TH-low half
   // reads all ones as the 6-button identification pattern.
   typedef logic [2:0] phase_t;

   localparam phase_t PH_IDLE   = 3'd0;
   localparam phase_t PH_ONE    = 3'd1;
   localparam phase_t PH_TWO    = 3'd2;
   localparam phase_t PH_EXT    = 3'd3;
   localparam phase_t PH_EXT_LO = 3'd4;

   // Value returned on every pin of a port that is held in reset or not fitted
   localparam logic [PAD_W-1:0] PINS_IDLE = 7'h7f;

endpackage

// File: rtl/md_pad_channel.sv
// One controller port: TH edge detector, 6-button phase counter with its
// inactivity timeout, pad data multiplexer and the registered pin resolver.
module md_pad_channel
   import md_pad_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 80000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PAD_W-1:0] drive,
   input  logic [PAD_W-1:0] dir,
   input  logic [BTN_W-1:0] btn,
   input  logic             mode6,
   output logic [PAD_W-1:0] pins
);

   // Counter wide enough to hold TIMEOUT_CYCLES-1, where it saturates
   localparam int IDLE_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES - 1);

   logic              th_q;
   phase_t            f;
   logic [IDLE_W-1:0] idle;
   logic [PAD_W-1:0]  pins_p1;

   logic              th_eff;
   logic              th_edge;
   logic              th_fall;
   logic              timeout;
   logic [IDLE_W-1:0] idle_nxt;
   phase_t            f_nxt;
   logic [5:0]        pad;
   logic [PAD_W-1:0]  pins_nxt;

   // Idle count that stops at the timeout value instead of wrapping
   function automatic logic [IDLE_W-1:0] idle_sat_inc(input logic [IDLE_W-1:0] v);
      logic [IDLE_W-1:0] r;
      if (v == IDLE_MAX) r = v;
      else               r = v + 1'b1;
      return r;
   endfunction

   // Phase advance on a TH falling edge; the 6-button pad wraps to phase 1
   // after its identification phase, never back to idle
   function automatic phase_t phase_adv(input phase_t ph);
      phase_t r;
      if (ph >= PH_EXT_LO) r = PH_ONE;
      else                 r = ph + 3'd1;
      return r;
   endfunction

   // Active-low D5..D0 presented by the pad for a given TH level and phase
   function automatic logic [5:0] pad_row(input logic th, input phase_t ph,
                                          input logic [BTN_W-1:0] b);
      logic [5:0] row;
      if (th) begin
         if (ph == PH_EXT)
            row = ~{b[BTN_C], b[BTN_B], b[BTN_MODE], b[BTN_X], b[BTN_Y], b[BTN_Z]};
         else
            row = ~{b[BTN_C], b[BTN_B], b[BTN_RIGHT], b[BTN_LEFT], b[BTN_DOWN], b[BTN_UP]};
      end else begin
         case (ph)
            PH_EXT:    row = {~b[BTN_START], ~b[BTN_A], 4'b0000};
            PH_EXT_LO: row = {~b[BTN_START], ~b[BTN_A], 4'b1111};
            default:   row = {~b[BTN_START], ~b[BTN_A], 2'b00, ~b[BTN_DOWN], ~b[BTN_UP]};
         endcase
      end
      return row;
   endfunction

   // Next-state for TH tracking, idle timer and phase, plus the pin value
   // built from the phase this edge will produce so data and phase never skew
   always_comb begin
      th_eff   = dir[TH_BIT] ? 1'b1 : drive[TH_BIT];
      th_edge  = th_q ^ th_eff;
      th_fall  = th_q & ~th_eff;
      idle_nxt = th_edge ? '0 : idle_sat_inc(idle);
      // An edge on the cycle the counter reaches its limit wins over the timeout
      timeout  = !th_edge && (idle_nxt == IDLE_MAX);

      f_nxt = f;
      if (!mode6)       f_nxt = PH_IDLE;
      else if (th_fall) f_nxt = phase_adv(f);
      else if (timeout) f_nxt = PH_IDLE;

      pad = pad_row(th_eff, f_nxt, btn);

      // Chip-driven pins read back the chip's own value; tri-stated ones see the pad
      pins_nxt         = '0;
      pins_nxt[TH_BIT] = th_eff;
      pins_nxt[5:0]    = (dir[5:0] & pad) | (~dir[5:0] & drive[5:0]);
   end

   // --- stage p1: registered phase state and resolved pins ---
   always_ff @(posedge clk) begin
      if (rst) begin
         th_q    <= 1'b1;
         f       <= PH_IDLE;
         idle    <= '0;
         pins_p1 <= PINS_IDLE;
      end else begin
         th_q    <= th_eff;
         f       <= f_nxt;
         idle    <= idle_nxt;
         pins_p1 <= pins_nxt;
      end
   end

   assign pins = pins_p1;

endmodule

// File: rtl/md_pad_ports.sv
// Controller-port block on the FC1004 PA/PB/PC pins. One independent pad
// channel per fitted port; the board ties any unfitted port to 7'h7f.
// NUM_PORTS must be 1..3 and TIMEOUT_CYCLES at least 2.
module md_pad_ports
   import md_pad_pkg::*;
#(
   parameter int NUM_PORTS      = 3,
   parameter int TIMEOUT_CYCLES = 80000
) (
   input  logic                       MCLK,
   input  logic                       ext_reset,
   input  logic [PAD_W*NUM_PORTS-1:0] port_o,
   input  logic [PAD_W*NUM_PORTS-1:0] port_d,
   input  logic [BTN_W*NUM_PORTS-1:0] btn,
   input  logic [NUM_PORTS-1:0]       mode6,
   output logic [PAD_W*NUM_PORTS-1:0] port_i
);

   // Slice the flat board vectors into one channel per port (0 = PA, 1 = PB, 2 = PC)
   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      md_pad_channel #(
         .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
      ) u_channel (
         .clk   (MCLK),
         .rst   (ext_reset),
         .drive (port_o[p*PAD_W +: PAD_W]),
         .dir   (port_d[p*PAD_W +: PAD_W]),
         .btn   (btn[p*BTN_W +: BTN_W]),
         .mode6 (mode6[p]),
         .pins  (port_i[p*PAD_W +: PAD_W])
      );
   end

endmodule

// File: doc/md_pad_ports.md
# md_pad_ports

Parametrised controller-port block for the MD board model. It sits on the FC1004 PA/PB/PC pins and replaces the fixed 7'h7f pull-up tie-off. Each port emulates a 3- or 6-button pad, selected per port, with the 6-button TH phase sequencer and its inactivity timeout. Where the chip drives a pin as an output, the pin value is resolved from the chip's drive instead of the pad's.

## Interface
Parameters:
- NUM_PORTS, 3, number of pad ports instantiated (1..3; port 0 = PA, 1 = PB, 2 = PC).
- TIMEOUT_CYCLES, 80000, MCLK cycles with no TH edge before the 6-button phase resets (about 1.5 ms at 53.69 MHz); must be ≥ 2.

Ports:
- MCLK  in  1  system clock; the only clock.
- ext_reset  in  1  reset; synchronous, active-high.
- port_o  in  7*NUM_PORTS  chip pin drive values; bit 6 = TH, bits 5..0 = D5..D0.
- port_d  in  7*NUM_PORTS  chip pin direction; 1 = chip tri-stated, 0 = chip drives.
- btn  in  12*NUM_PORTS  buttons, active-high; per-port index 0..11 = Up, Down, Left, Right, A, B, C, Start, X, Y, Z, Mode.
- mode6  in  NUM_PORTS  1 = 6-button pad, 0 = 3-button pad.
- port_i  out  7*NUM_PORTS  resolved pin values returned to the chip (PA_i/PB_i/PC_i).

## Operation
- TH_eff = port_d[6] ? 1 (board pull-up) : port_o[6]. The pad never drives TH.
- Phase counter f, 3 bits, per port:
  - On TH_eff falling edge (th_q=1, TH_eff=0) with mode6=1: f ← (f ≥ 4) ? 1 : f+1.
  - Timeout, or mode6=0: f ← 0.
- Idle counter, per port:
  - Cleared on any TH_eff edge.
  - Otherwise increments and saturates at TIMEOUT_CYCLES-1.
  - Reaching TIMEOUT_CYCLES-1 forces f ← 0 on that cycle.
  - A TH edge on that same cycle takes priority: it applies the edge update and clears the counter.
- Pad data D5..D0, active-low (pressed = 0):
  - TH=1, f≠3: C, B, Right, Left, Down, Up.
  - TH=1, f=3: C, B, Mode, X, Y, Z.
  - TH=0, f∈{0,1,2}: Start, A, 0, 0, Down, Up.
  - TH=0, f=3: Start, A, 0, 0, 0, 0.
  - TH=0, f=4: Start, A, 1, 1, 1, 1.
  - In 3-button mode f is always 0, so only the normal rows apply.
- Pin resolution, per bit b:
  - port_i[b] = port_d[b] ? pad[b] : port_o[b].
  - Bit 6 = TH_eff.
- Ports are fully independent. Identical stimulus must give identical results on every port.

## Timing
- All state and port_i are registered on MCLK.
- port_i at edge k+1 reflects the inputs sampled at edge k, using the f value that results from edge k. Latency is 1 cycle, and there is no cycle where the data disagrees with the phase.
- th_q holds the previous TH_eff for edge detection. Edges are detected with 1-cycle resolution; a TH pulse must be at least 1 cycle wide.
- Reset values (ext_reset=1 at an edge): f=0, idle=0, th_q=1, port_i = 7'h7f on every port. Reset overrides all events, including one mid-sequence.
- Boundaries:
  - A TH edge exactly TIMEOUT_CYCLES-1 cycles after the previous one is not a timeout.
  - A mode6 change takes effect on the next edge.
  - Button changes appear after 1 cycle, with no debounce.

## Structure
- Package md_pad_pkg holds:
  - PAD_W=7, BTN_W=12, TH_BIT=6.
  - Button index localparams BTN_UP … BTN_MODE.
  - Phase constants PH_IDLE=0 … PH_EXT_LO=4.
- Sub-module md_pad_channel holds one port's th_q, f, idle counter and output register. md_pad_ports is a generate loop over NUM_PORTS plus vector slicing.
- Board integration: PA/PB/PC connect to port_i slices. Any port not instantiated stays tied to 7'h7f.

## Test plan
- Reset: hold ext_reset with random buttons and pins -> port_i = 7'h7f on all ports during reset and on the first edge after release.
- 3-button, TH pulled up, C+Up pressed -> port_i = 7'b1_011110. Drive TH=0 with Start pressed -> 7'b0_010011 one cycle later.
- 6-button with X+Mode pressed; toggle TH low/high 4 times, then hold TH high:
  - 3rd low -> bits 3:0 = 0000.
  - Following high -> bits 5:0 = 6'b110011.
  - 4th low -> bits 3:0 = 1111.
  - Next high -> normal C B R L D U row.
- Timeout:
  - After 2 lows, hold TH high for exactly TIMEOUT_CYCLES cycles -> the next 3rd-low reads normal Down/Up rather than 0000.
  - Repeat with a gap of TIMEOUT_CYCLES-1 cycles -> 0000 still appears.
- Chip drive: port_d[3:0]=0, port_o[3:0]=4'b1010, all buttons pressed -> port_i[3:0]=1010. Bits 5:4 follow the pad.
- Reset and mode change mid-sequence, f=3, TH high:
  - Pulse ext_reset for 1 cycle -> next cycle shows the normal row.
  - Separately, deassert mode6 -> f=0 and the normal row appears one cycle later.
